// File: rtl/instr_reg_ctrl.sv
// Round-robin write arbiter and circular-FIFO pointer controller for the
// 32-entry instruction register; the stored entries are drained through a valid/ready port.
module instr_reg_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [66:0]   req0_instr,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [66:0]   req1_instr,
  output logic          load_en,
  output logic [AW-1:0] write_pointer,
  output logic [2:0]    opcode,
  output logic [31:0]   operand_a,
  output logic [31:0]   operand_b,
  output logic [AW-1:0] read_pointer,
  input  logic [66:0]   instruction_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [66:0]   out_instr,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [2:0]  opc;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } instruction_t;

  localparam logic [AW:0]   LP_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LP_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

  // Handshake rule for both ports: a transfer happens on a posedge where
  // valid and ready are both high; ready may follow valid combinationally.

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_last_grant;

  logic          w_full;
  logic          w_empty;
  logic          w_can_accept;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_push;
  logic          w_pop;
  instruction_t  w_sel;

  assign w_full       = (r_count == LP_FULL);
  assign w_empty      = (r_count == '0);
  assign w_can_accept = !w_full && !flush && !reset;

  // On a tie the port that did not win the previous accept gets the slot.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_can_accept) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_push = w_grant0 || w_grant1;
  assign w_sel  = instruction_t'(w_grant1 ? req1_instr : req0_instr);

  assign req0_ready    = w_grant0;
  assign req1_ready    = w_grant1;
  assign load_en       = w_push;
  assign write_pointer = r_wr_ptr;
  assign opcode        = w_push ? w_sel.opc  : '0;
  assign operand_a     = w_push ? w_sel.op_a : '0;
  assign operand_b     = w_push ? w_sel.op_b : '0;

  assign out_valid    = !w_empty && !reset;
  assign out_instr    = instruction_word;
  assign read_pointer = r_rd_ptr;
  assign count        = r_count;
  assign w_pop        = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + AW'(1);
        r_last_grant <= w_grant1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl: a behavioural 32-entry register array,
// a driver that queues expected instructions, and a monitor that pops them.
module tb_instr_reg_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam logic [2:0] ADD = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] MUL = 3'd3;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          req0_valid;
  logic          req0_ready;
  logic [66:0]   req0_instr;
  logic          req1_valid;
  logic          req1_ready;
  logic [66:0]   req1_instr;
  logic          load_en;
  logic [AW-1:0] write_pointer;
  logic [2:0]    opcode;
  logic [31:0]   operand_a;
  logic [31:0]   operand_b;
  logic [AW-1:0] read_pointer;
  logic [66:0]   instruction_word;
  logic          out_valid;
  logic          out_ready;
  logic [66:0]   out_instr;
  logic [AW:0]   count;

  logic [66:0] mem [DEPTH];
  logic [66:0] exp_q[$];
  int n_checks;
  int n_fail;

  instr_reg_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .count(count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural instruction register
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
  end
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  end
  assign instruction_word = mem[read_pointer];

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expected entry per consumer handshake
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no entry at %0t", out_instr, $time);
      end else begin
        check("pop_data", out_instr, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [66:0] mk(input logic [2:0] op, input int a, input int b);
    return {op, 32'(a), 32'(b)};
  endfunction

  task automatic reset_dut();
    reset      = 1'b1;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_one(input int port, input logic [66:0] instr, input int exp_wp);
    if (port == 0) begin
      req0_valid = 1'b1;
      req0_instr = instr;
    end else begin
      req1_valid = 1'b1;
      req1_instr = instr;
    end
    settle();
    check("push_ready", (port == 0) ? req0_ready : req1_ready, 1);
    check("push_load_en", load_en, 1);
    check("push_wp", write_pointer, exp_wp);
    exp_q.push_back(instr);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (count == 0) break;
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_instr = mk(ADD, 9, 9);
    req1_instr = mk(SUB, 8, 8);
    out_ready  = 1'b1;

    // reset state, with both producers offering
    tick();
    settle();
    check("rst_load_en", load_en, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_opcode", opcode, 0);
    tick();
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    settle();
    check("rst_count", count, 0);
    check("rst_rp", read_pointer, 0);

    // 1: single push, visible the following cycle
    req0_valid = 1'b1;
    req0_instr = mk(ADD, 5, 3);
    settle();
    check("t1_load_en", load_en, 1);
    check("t1_wp", write_pointer, 0);
    check("t1_opcode", opcode, ADD);
    check("t1_op_a", operand_a, 5);
    check("t1_op_b", operand_b, 3);
    check("t1_out_valid_before", out_valid, 0);
    exp_q.push_back(mk(ADD, 5, 3));
    tick();
    req0_valid = 1'b0;
    settle();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_instr", out_instr, mk(ADD, 5, 3));
    check("t1_count", count, 1);
    check("t1_idle_op_a", operand_a, 0);
    drain();

    // 2: both valid every cycle alternates grants 0,1,0,1
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_instr = mk(SUB, 100 + i, i);
      req1_instr = mk(MUL, 200 + i, i);
      settle();
      check("t2_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("t2_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
      check("t2_wp", write_pointer, i);
      check("t2_op_a", operand_a, (i % 2 == 0) ? 100 + i : 200 + i);
      exp_q.push_back((i % 2 == 0) ? mk(SUB, 100 + i, i) : mk(MUL, 200 + i, i));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    check("t2_count", count, 4);
    drain();

    // 3: fill to full, pop one, write pointer wraps
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      push_one(0, mk(i[2:0], i * 3, ~i), i);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_instr = mk(ADD, 777, 1);
    req1_instr = mk(SUB, 888, 2);
    settle();
    check("t3_count_full", count, DEPTH);
    check("t3_full_req0_ready", req0_ready, 0);
    check("t3_full_req1_ready", req1_ready, 0);
    check("t3_full_load_en", load_en, 0);
    check("t3_full_opcode", opcode, 0);
    out_ready = 1'b1;
    settle();
    check("t3_pop_req0_ready", req0_ready, 0);
    tick();
    out_ready  = 1'b0;
    req1_valid = 1'b0;
    settle();
    check("t3_count_after_pop", count, DEPTH - 1);
    check("t3_wrap_ready", req0_ready, 1);
    check("t3_wrap_wp", write_pointer, 0);
    exp_q.push_back(mk(ADD, 777, 1));
    tick();
    req0_valid = 1'b0;
    settle();
    check("t3_count_refull", count, DEPTH);
    drain();
    check("t3_rp_wrap", read_pointer, 1);

    // 4: simultaneous push and pop keep occupancy
    reset_dut();
    for (int i = 0; i < 5; i++) push_one(1, mk(MUL, 40 + i, i), i);
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1;
      req0_instr = mk(ADD, 60 + i, 7);
      out_ready  = 1'b1;
      settle();
      check("t4_ready", req0_ready, 1);
      check("t4_wp", write_pointer, 5 + i);
      check("t4_rp", read_pointer, i);
      exp_q.push_back(mk(ADD, 60 + i, 7));
      tick();
      req0_valid = 1'b0;
      out_ready  = 1'b0;
      settle();
      check("t4_count", count, 5);
    end
    check("t4_rp_after", read_pointer, 2);
    drain();

    // 5: flush blocks accept, clears pointers, keeps arbitration history
    reset_dut();
    for (int i = 0; i < 7; i++) push_one(0, mk(SUB, 70 + i, i), i);
    flush      = 1'b1;
    req0_valid = 1'b1;
    req0_instr = mk(ADD, 1, 1);
    out_ready  = 1'b1;
    settle();
    check("t5_flush_ready", req0_ready, 0);
    check("t5_flush_load_en", load_en, 0);
    tick();
    flush      = 1'b0;
    req0_valid = 1'b0;
    out_ready  = 1'b0;
    exp_q.delete();
    settle();
    check("t5_count", count, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_rp", read_pointer, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_instr = mk(ADD, 11, 0);
    req1_instr = mk(MUL, 22, 0);
    settle();
    check("t5_tie_req1_ready", req1_ready, 1);
    check("t5_tie_req0_ready", req0_ready, 0);
    check("t5_wp", write_pointer, 0);
    exp_q.push_back(mk(MUL, 22, 0));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // 6: reset during an offered req1 transfer
    reset_dut();
    for (int i = 0; i < 3; i++) push_one(0, mk(ADD, 90 + i, i), i);
    reset      = 1'b1;
    req1_valid = 1'b1;
    req1_instr = mk(SUB, 99, 9);
    settle();
    check("t6_rst_ready", req1_ready, 0);
    check("t6_rst_load_en", load_en, 0);
    check("t6_rst_out_valid", out_valid, 0);
    tick();
    reset      = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    settle();
    check("t6_count", count, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_load_en", load_en, 0);
    check("t6_rp", read_pointer, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_instr = mk(ADD, 33, 3);
    req1_instr = mk(SUB, 44, 4);
    settle();
    check("t6_tie_req0_ready", req0_ready, 1);
    check("t6_tie_req1_ready", req1_ready, 0);
    check("t6_wp", write_pointer, 0);
    exp_q.push_back(mk(ADD, 33, 3));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
